// File: rtl/fib_unit.sv
`default_nettype none
// ============================================================================
// Module      : fib_unit
// Description : Iterative Fibonacci engine. Captures index n on an accepted
//               start, performs one W-bit addition per clock and presents
//               F(n) (wrapped, or saturated when FIB_SAT_EN is defined) with
//               a true-value overflow flag and a one-cycle done pulse.
// Options     : FIB_SAT_EN - saturate result to all-ones when F(n) >= 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         a_ovf_q, a_ovf_d;
  logic         b_ovf_q, b_ovf_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d;

  // Extra MSB holds the carry-out of a+b, which feeds the overflow tracking.
  logic [W:0]   sum;

  // One W-bit adder shared by every RUN step.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // State, accumulators and result registers; reset discards any computation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      a_ovf_q  <= 1'b0;
      b_ovf_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      a_ovf_q  <= a_ovf_d;
      b_ovf_q  <= b_ovf_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update; everything holds unless a step applies.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    a_ovf_d  = a_ovf_q;
    b_ovf_d  = b_ovf_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          b_d     = W'(1);
          cnt_d   = n;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (cnt_q != '0) begin
          // a/b hold F(i)/F(i+1); each flag records whether the true value
          // reached 2^W, so a wrap of b alone never taints the result for n.
          a_d     = b_q;
          b_d     = sum[W-1:0];
          cnt_d   = cnt_q - W'(1);
          b_ovf_d = b_ovf_q | a_ovf_q | sum[W];
          a_ovf_d = b_ovf_q;
        end else begin
`ifdef FIB_SAT_EN
          result_d = a_ovf_q ? {W{1'b1}} : a_q;
`else
          result_d = a_q;
`endif
          ovf_d   = a_ovf_q;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_unit
// Description : Self-checking bench for fib_unit: directed scenarios plus
//               random indices checked against an arithmetic Fibonacci model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_unit;

  localparam int W = 16;
  localparam longint unsigned LIMIT = 64'd1 << W;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int compared   = 0;
  int mismatched = 0;

  fib_unit #(.W(W)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design never answers.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: F(n) mod 2^W, and whether the true F(n) reaches 2^W.
  // The second sequence is clamped at 2^W, which preserves the >= test.
  function automatic void ref_fib(input int unsigned nn, output logic [W-1:0] r, output logic o);
    longint unsigned x = 0, y = 1, t;
    longint unsigned xc = 0, yc = 1, tc;
    for (int i = 0; i < int'(nn); i++) begin
      t  = (x + y) % LIMIT;
      x  = y;
      y  = t;
      tc = xc + yc;
      if (tc > LIMIT) tc = LIMIT;
      xc = yc;
      yc = tc;
    end
    o = (xc >= LIMIT);
`ifdef FIB_SAT_EN
    r = o ? {W{1'b1}} : W'(x);
`else
    r = W'(x);
`endif
  endfunction

  // One full transaction from IDLE: accept, latency, result, return to IDLE.
  task automatic run_op(input logic [W-1:0] nn, input string tag);
    logic [W-1:0] er;
    logic         eo;
    int           cyc;
    bit           seen;
    ref_fib(int'(nn), er, eo);
    @(negedge clk);
    start = 1'b1;
    n     = nn;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = W'($urandom);
    check({tag, "_busy_run"}, busy, 1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < int'(nn) + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, int'(nn) + 1);
    check({tag, "_result"}, result, er);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_busy_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic         eo;
    int           cyc;
    int           pulses;
    int           busy_hi;
    int           pulse_at[$];
    int unsigned  rn;

    rst_b = 1'b0;
    start = 1'b0;
    n     = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // n=10, then result must hold through a quiet period.
    run_op(W'(10), "n10");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      check("n10_hold", result, 55);
    end
    check("n10_hold_no_done", pulses, 0);

    // Smallest indices back to back.
    run_op(W'(0), "n0");
    run_op(W'(1), "n1");
    run_op(W'(2), "n2");

    // Largest index that fits, then the first that overflows.
    run_op(W'(24), "n24");
    check("n24_value", result, 16'hB520);
    run_op(W'(25), "n25");
    check("n25_ovf_flag", ovf, 1);

    // Start pulses during RUN and in DONE are ignored.
    @(negedge clk);
    start = 1'b1;
    n     = W'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    n     = W'(20);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 2;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ign_latency", cyc, 6);
    check("ign_done", done, 1);
    @(negedge clk);
    start = 1'b1;
    n     = W'(20);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_idle_after_done", busy, 0);
    pulses  = 0;
    busy_hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (busy) busy_hi++;
    end
    check("ign_no_extra_done", pulses, 0);
    check("ign_stays_idle", busy_hi, 0);
    check("ign_result", result, 5);

    // Asynchronous reset in the middle of a long computation.
    @(negedge clk);
    start = 1'b1;
    n     = W'(100);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;
    run_op(W'(7), "after_rst");

    // Start held high: recomputes every n+3 cycles (DONE, one IDLE, n+1 RUN).
    @(negedge clk);
    start = 1'b1;
    n     = W'(3);
    cyc   = 0;
    while (pulse_at.size() < 3 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        pulse_at.push_back(cyc);
        check("held_result", result, 2);
        check("held_ovf", ovf, 0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held_pulses", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      check("held_first", pulse_at[0], 5);
      check("held_period1", pulse_at[1] - pulse_at[0], 6);
      check("held_period2", pulse_at[2] - pulse_at[1], 6);
    end
    @(posedge clk);
    #1;
    check("held_idle", busy, 0);

    // Random indices, mostly small, some long enough to wrap many times.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) rn = $urandom_range(0, 400);
      else                           rn = $urandom_range(0, 40);
      run_op(W'(rn), $sformatf("rand%0d_n%0d", i, rn));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
